// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns game events into short note sequences and steps the
// 5-bit sine ROM address at the pitch of the current note.
module sfx_sequencer #(
  parameter int unsigned DIV_DO   = 2986,
  parameter int unsigned DIV_RE   = 2660,
  parameter int unsigned DIV_MI   = 2369,
  parameter int unsigned DIV_SOL  = 1993,
  parameter int unsigned NOTE_LEN = 2500000,
  parameter int unsigned GAP_LEN  = 250000
) (
  input  logic       clk50mhz,
  input  logic       reset_button,
  input  logic       evt_paddle,
  input  logic       evt_wall,
  input  logic       evt_brick,
  input  logic       evt_lose,
  output logic [4:0] address_audio,
  output logic [1:0] note,
  output logic       sound_on,
  output logic       busy
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DivMax = max2(max2(DIV_DO, DIV_RE), max2(DIV_MI, DIV_SOL));
  localparam int unsigned PitchW = max2($clog2(2 * DivMax), 1);
  localparam int unsigned DurMax = max2(NOTE_LEN, GAP_LEN);
  localparam int unsigned DurW   = max2($clog2(DurMax), 1);

  localparam logic [PitchW-1:0] TermDo  = PitchW'(2 * DIV_DO - 1);
  localparam logic [PitchW-1:0] TermRe  = PitchW'(2 * DIV_RE - 1);
  localparam logic [PitchW-1:0] TermMi  = PitchW'(2 * DIV_MI - 1);
  localparam logic [PitchW-1:0] TermSol = PitchW'(2 * DIV_SOL - 1);
  localparam logic [DurW-1:0]   NoteTerm = DurW'(NOTE_LEN - 1);
  localparam logic [DurW-1:0]   GapTerm  = DurW'(GAP_LEN - 1);

  // Sequence ids double as priorities: wall < paddle < brick < lose.
  function automatic logic [1:0] seq_note(input logic [1:0] seq, input logic [1:0] idx);
    logic [1:0] n;
    unique case (seq)
      2'd0: n = 2'd3;
      2'd1: n = 2'd0;
      2'd2: n = (idx == 2'd0) ? 2'd2 : 2'd3;
      2'd3: n = 2'd3 - idx;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] seq_last(input logic [1:0] seq);
    logic [1:0] l;
    unique case (seq)
      2'd0: l = 2'd0;
      2'd1: l = 2'd0;
      2'd2: l = 2'd1;
      2'd3: l = 2'd3;
    endcase
    return l;
  endfunction

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  logic [3:0] evt_raw;
  logic [3:0] sync1_q, sync2_q, prev_q, rise_q;
  logic [1:0] prime_q;

  assign evt_raw = {evt_lose, evt_brick, evt_paddle, evt_wall};

  // prime_q blocks edges until the history flop holds a real post-reset sample,
  // so an event held through reset is not mistaken for a new rise.
  always_ff @(posedge clk50mhz or posedge reset_button) begin
    if (reset_button) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= evt_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= (prime_q == 2'd3) ? (sync2_q & ~prev_q) : 4'd0;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  logic       ev_valid;
  logic [1:0] ev_pri;

  always_comb begin
    ev_valid = |rise_q;
    ev_pri   = 2'd0;
    if (rise_q[3])      ev_pri = 2'd3;
    else if (rise_q[2]) ev_pri = 2'd2;
    else if (rise_q[1]) ev_pri = 2'd1;
  end

  state_e            state_q;
  logic [1:0]        seq_q, idx_q;
  logic [PitchW-1:0] pitch_q, pitch_term;
  logic [DurW-1:0]   dur_q;

  always_comb begin
    pitch_term = TermDo;
    unique case (note)
      2'd0: pitch_term = TermDo;
      2'd1: pitch_term = TermRe;
      2'd2: pitch_term = TermMi;
      2'd3: pitch_term = TermSol;
    endcase
  end

  always_ff @(posedge clk50mhz or posedge reset_button) begin
    if (reset_button) begin
      state_q       <= StIdle;
      seq_q         <= '0;
      idx_q         <= '0;
      pitch_q       <= '0;
      dur_q         <= '0;
      address_audio <= '0;
      note          <= '0;
      sound_on      <= 1'b0;
      busy          <= 1'b0;
    end else if (ev_valid && (state_q == StIdle || ev_pri >= seq_q)) begin
      state_q       <= StPlay;
      seq_q         <= ev_pri;
      idx_q         <= '0;
      pitch_q       <= '0;
      dur_q         <= '0;
      address_audio <= '0;
      note          <= seq_note(ev_pri, 2'd0);
      sound_on      <= 1'b1;
      busy          <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPlay: begin
          if (pitch_q == pitch_term) begin
            pitch_q       <= '0;
            address_audio <= address_audio + 5'd1;
          end else begin
            pitch_q <= pitch_q + 1'b1;
          end
          if (dur_q == NoteTerm) begin
            dur_q         <= '0;
            pitch_q       <= '0;
            address_audio <= '0;
            sound_on      <= 1'b0;
            if (idx_q == seq_last(seq_q)) begin
              state_q <= StIdle;
              idx_q   <= '0;
              note    <= '0;
              busy    <= 1'b0;
            end else begin
              state_q <= StGap;
              idx_q   <= idx_q + 2'd1;
            end
          end else begin
            dur_q <= dur_q + 1'b1;
          end
        end
        StGap: begin
          if (dur_q == GapTerm) begin
            state_q  <= StPlay;
            dur_q    <= '0;
            pitch_q  <= '0;
            note     <= seq_note(seq_q, idx_q);
            sound_on <= 1'b1;
          end else begin
            dur_q <= dur_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: timeline-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sfx_sequencer;

  localparam int DIV_DO = 7, DIV_RE = 6, DIV_MI = 5, DIV_SOL = 4;
  localparam int NOTE_LEN = 64, GAP_LEN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt_paddle = 1'b0, evt_wall = 1'b0, evt_brick = 1'b0, evt_lose = 1'b0;
  logic [4:0] address_audio;
  logic [1:0] note;
  logic       sound_on, busy;

  sfx_sequencer #(
    .DIV_DO(DIV_DO), .DIV_RE(DIV_RE), .DIV_MI(DIV_MI), .DIV_SOL(DIV_SOL),
    .NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk50mhz(clk),
    .reset_button(rst),
    .evt_paddle(evt_paddle),
    .evt_wall(evt_wall),
    .evt_brick(evt_brick),
    .evt_lose(evt_lose),
    .address_audio(address_audio),
    .note(note),
    .sound_on(sound_on),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a start edge plus a note list; outputs follow from
  // the elapsed time since that start.
  int notes_tab [4][4] = '{'{3, 0, 0, 0}, '{0, 0, 0, 0}, '{2, 3, 0, 0}, '{3, 2, 1, 0}};
  int len_tab [4] = '{1, 1, 2, 4};
  int div_tab [4] = '{DIV_DO, DIV_RE, DIV_MI, DIV_SOL};

  int       edge_cnt = 0;
  int       samp_idx = 0;
  bit [3:0] prev_in = '0;
  bit [3:0] d0 = '0, d1 = '0, d2 = '0;
  bit       m_active = 1'b0;
  int       m_start = 0;
  int       m_seq = 0;

  function automatic int seq_total(input int s);
    return len_tab[s] * NOTE_LEN + (len_tab[s] - 1) * GAP_LEN;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit [3:0] cur, rise, act;
    int pri;
    bit was_busy;
    if (rst) begin
      edge_cnt = 0;
      samp_idx = 0;
      d0 = '0; d1 = '0; d2 = '0;
      m_active = 1'b0;
    end else begin
      cur  = {evt_lose, evt_brick, evt_paddle, evt_wall};
      rise = (samp_idx >= 1) ? (cur & ~prev_in) : 4'd0;
      prev_in = cur;
      samp_idx++;
      // A rise sampled at edge n takes effect at edge n+3.
      act = d2;
      d2 = d1; d1 = d0; d0 = rise;
      if (act != 0) begin
        pri = 0;
        for (int p = 0; p < 4; p++) if (act[p]) pri = p;
        was_busy = m_active && ((edge_cnt - 1 - m_start) < seq_total(m_seq));
        if (!was_busy || pri >= m_seq) begin
          m_active = 1'b1;
          m_start  = edge_cnt;
          m_seq    = pri;
        end
      end
      edge_cnt++;
    end
  end

  always @(negedge clk) begin
    int t, i, o, nt;
    int e_addr, e_note, e_sound, e_busy;
    e_addr = 0; e_note = 0; e_sound = 0; e_busy = 0;
    if (m_active) begin
      t = edge_cnt - 1 - m_start;
      if (t < seq_total(m_seq)) begin
        i  = t / (NOTE_LEN + GAP_LEN);
        o  = t % (NOTE_LEN + GAP_LEN);
        nt = notes_tab[m_seq][i];
        e_note = nt;
        e_busy = 1;
        if (o < NOTE_LEN) begin
          e_sound = 1;
          e_addr  = (o / (2 * div_tab[nt])) % 32;
        end
      end
    end
    check("model_address", int'(address_audio), e_addr);
    check("model_note", int'(note), e_note);
    check("model_sound_on", int'(sound_on), e_sound);
    check("model_busy", int'(busy), e_busy);
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(200);
    check("idle_sound_on", int'(sound_on), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_address", int'(address_audio), 0);

    // Paddle: single DO note, address steps every 14 cycles.
    @(negedge clk); evt_paddle = 1'b1;
    step(1); step(2);
    check("paddle_latency_pre", int'(sound_on), 0);
    step(1);
    check("paddle_sound_on", int'(sound_on), 1);
    check("paddle_note", int'(note), 0);
    check("paddle_busy", int'(busy), 1);
    step(13);
    check("paddle_addr_t13", int'(address_audio), 0);
    step(1);
    check("paddle_addr_t14", int'(address_audio), 1);
    step(49);
    check("paddle_addr_t63", int'(address_audio), 4);
    step(1);
    check("paddle_end_sound", int'(sound_on), 0);
    check("paddle_end_busy", int'(busy), 0);
    check("paddle_end_addr", int'(address_audio), 0);
    @(negedge clk); evt_paddle = 1'b0;
    step(5);

    // Lose pulse: SOL, MI, RE, DO with 8-cycle gaps, 280 cycles total.
    @(negedge clk); evt_lose = 1'b1;
    @(negedge clk); evt_lose = 1'b0;
    step(3);
    check("lose_note0", int'(note), 3);
    step(63);
    check("lose_addr_t63", int'(address_audio), 7);
    step(1);
    check("lose_gap_sound", int'(sound_on), 0);
    check("lose_gap_busy", int'(busy), 1);
    check("lose_gap_note", int'(note), 3);
    step(8);
    check("lose_note1", int'(note), 2);
    check("lose_note1_sound", int'(sound_on), 1);
    step(207);
    check("lose_note3", int'(note), 0);
    check("lose_note3_sound", int'(sound_on), 1);
    step(1);
    check("lose_end_busy", int'(busy), 0);
    step(5);

    // Wall and brick together: brick wins; a later wall rise is ignored.
    @(negedge clk); evt_wall = 1'b1; evt_brick = 1'b1;
    step(1); step(3);
    check("brick_note0", int'(note), 2);
    @(negedge clk); evt_wall = 1'b0;
    step(4);
    @(negedge clk); evt_wall = 1'b1;
    step(10);
    check("wall_ignored_note", int'(note), 2);
    check("wall_ignored_addr", int'(address_audio), 1);
    step(58);
    check("brick_note1", int'(note), 3);
    step(64);
    check("brick_end_busy", int'(busy), 0);
    @(negedge clk); evt_wall = 1'b0; evt_brick = 1'b0;
    step(3);

    // Brick preempted by lose.
    @(negedge clk); evt_brick = 1'b1;
    step(1); step(3);
    check("brick2_note0", int'(note), 2);
    step(20);
    @(negedge clk); evt_lose = 1'b1;
    step(1); step(3);
    check("preempt_note", int'(note), 3);
    check("preempt_addr", int'(address_audio), 0);
    check("preempt_sound", int'(sound_on), 1);
    step(30);

    // Async reset mid-note with events held high through reset.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst_sound", int'(sound_on), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_note", int'(note), 0);
    check("async_rst_addr", int'(address_audio), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(100);
    check("held_no_sound", int'(sound_on), 0);
    check("held_no_busy", int'(busy), 0);
    @(negedge clk); evt_lose = 1'b0; evt_brick = 1'b0;
    step(4);
    @(negedge clk); evt_lose = 1'b1;
    step(1); step(2);
    check("rearm_pre", int'(sound_on), 0);
    step(1);
    check("rearm_sound", int'(sound_on), 1);
    check("rearm_note", int'(note), 3);
    step(300);
    check("rearm_end_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
